// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU result stage: opcodes, flag bit positions,
// saturation values and the buffered FIFO entry layout.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_NAND = 2'd2;
  localparam logic [1:0] OP_XOR  = 2'd3;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [3:0] SAT_POS = 4'h7;
  localparam logic [3:0] SAT_NEG = 4'h8;

  typedef struct packed {
    logic       ovfl;
    logic [3:0] result;
  } fifo_entry_t;

  // ADD/SUB are the only opcodes whose overflow and sign are meaningful.
  function automatic logic is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and the writeback consumer.
// The stage uses the slave modport; the environment driving it uses master.
interface alu_result_stage_if;

  logic       In_Valid;
  logic       In_Ready;
  logic [3:0] In_Result;
  logic       In_Ovfl;
  logic [1:0] In_Opcode;
  logic       Flush;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [3:0] Out_Result;
  logic       Out_Ovfl;
  logic [2:0] Flags;

  modport master (
    output In_Valid, In_Result, In_Ovfl, In_Opcode, Flush, Out_Ready,
    input  In_Ready, Out_Valid, Out_Result, Out_Ovfl, Flags
  );

  modport slave (
    input  In_Valid, In_Result, In_Ovfl, In_Opcode, Flush, Out_Ready,
    output In_Ready, Out_Valid, Out_Result, Out_Ovfl, Flags
  );

endinterface

// File: rtl/result_fifo.sv
// Circular-buffer FIFO with synchronous flush; the read port reads zero while empty.
// Push beyond full and pop from empty are ignored.
module result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 5,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the 4-bit ALU: Z/V/N flags plus a small result FIFO.
// Define ALU_RESULT_SAT_EN to saturate overflowing ADD/SUB results instead of wrapping.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu_result_stage_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            push, pop, arith;
  logic [CntW-1:0] count;
  logic [3:0]      res_r;
  fifo_entry_t     wr_entry, rd_entry;
  logic [2:0]      flags_q, flags_d;

  assign arith = is_arith(bus.In_Opcode);

  always_comb begin
    res_r = bus.In_Result;
`ifdef ALU_RESULT_SAT_EN
    // A set sign bit on overflow means the true result was positive.
    if (arith && bus.In_Ovfl) res_r = bus.In_Result[3] ? SAT_POS : SAT_NEG;
`endif
  end

  assign wr_entry.result = res_r;
  assign wr_entry.ovfl   = arith && bus.In_Ovfl;

  assign bus.In_Ready  = (count != CntW'(DEPTH));
  assign bus.Out_Valid = (count != '0);
  assign push          = bus.In_Valid && bus.In_Ready;
  assign pop           = bus.Out_Valid && bus.Out_Ready;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.Flush),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count)
  );

  assign bus.Out_Result = rd_entry.result;
  assign bus.Out_Ovfl   = rd_entry.ovfl;

  // A push dropped by Flush must not disturb the flags.
  always_comb begin
    flags_d = flags_q;
    if (push && !bus.Flush) begin
      flags_d[FLAG_Z] = (res_r == 4'h0);
      if (arith) begin
        flags_d[FLAG_V] = bus.In_Ovfl;
        flags_d[FLAG_N] = res_r[3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 3'b000;
    else        flags_q <= flags_d;
  end

  assign bus.Flags = flags_q;

endmodule
